pc_register: RTL and testbench
==============================

// Module: pc_register
// PURPOSE
//   Program-counter register for the 5-stage pipelined MIPS core, at the head of the IF stage.
//   Captures the next-PC value from the PC-select mux on each rising clock edge and drives it to
//   the instruction memory address and the PC+4 adder.
//   Supports a fetch stall (hold) from the hazard unit and a synchronous reset to a boot vector.
// PARAMETERS
//   WIDTH         32            PC width in bits
//   RESET_VECTOR  32'h0000_0000 Value loaded into Out on Reset
// PORTS
//   Clk        input   1      rising-edge clock; the only clock
//   Reset      input   1      synchronous, active-high reset
//   Stall      input   1      1 = hold current PC (load-use/hazard stall); 0 = load In
//   In         input   WIDTH  next PC from the PC-source mux
//   Out        output  WIDTH  current PC (registered)
//   OutPlus4   output  WIDTH  Out + 4, combinational, modulo 2^WIDTH
//   Misaligned output  1      1 when Out[1:0] != 2'b00 (registered with Out)
// BEHAVIOUR
//   - All state updates occur only on posedge Clk. No asynchronous paths.
//   - Priority at each edge: Reset > Stall > load.
//   - Reset=1: Out <= RESET_VECTOR; Misaligned <= (RESET_VECTOR[1:0] != 0). Stall and In are ignored.
//   - Reset=0, Stall=1: Out and Misaligned hold their values.
//   - Reset=0, Stall=0: Out <= In, so latency In->Out is exactly 1 cycle.
//     Misaligned <= (In[1:0] != 0).
//   - OutPlus4 = Out + 4 and wraps silently. For example, 32'hFFFF_FFFC -> 32'h0000_0000.
//     No carry output.
//   - Before the first reset or load, Out is undefined (X in simulation).
//     Integrators must assert Reset for at least 1 cycle at power-up.
//   - Reset asserted mid-stall still forces RESET_VECTOR on that edge.
//   - Deasserting Reset while Stall=1 holds RESET_VECTOR until Stall falls.
//   - In changing between edges has no effect on Out. Out is glitch-free and registered.
//   - An unconnected Reset (floating) is not supported; tie it to 0 if unused.
// CONFIGURATION
//   - Macro PC_ALIGN_FORCE_EN.
//   - Defined: the loaded value is In with bits [1:0] forced to 2'b00, so Out is always
//     word-aligned. Misaligned still reports whether the raw In had nonzero low bits
//     (sticky for that PC).
//   - Undefined: In is loaded verbatim. Misaligned reflects Out[1:0] only.
//   - Port list is identical in both builds.
// STRUCTURE
//   - Shared package mips_pkg holds:
//     - PC_WIDTH = 32, PC_RESET_VECTOR
//     - INSTR_BYTES = 4, the OutPlus4 increment
//   - One natural sub-module: dff_en_rst #(WIDTH, RST_VAL), a generic register with
//     synchronous active-high reset and enable.
//   - pc_register instantiates it with enable = ~Stall. The remainder is the +4 adder
//     and the alignment logic.
// TESTING
//   - Clk period 10 ns.
//   - Reset 2 cycles, In=32'd0 -> Out=RESET_VECTOR, Misaligned=0, OutPlus4=32'd4.
//   - Reset=0, In=0, then In=200 at t=100 ns -> Out=0 until the next edge, then Out=200 and
//     stays 200. OutPlus4=204.
//   - In=300 at t=300 ns -> Out=300 one edge later, with no intermediate value.
//   - Stall=1 for 3 cycles while In=400 -> Out holds 300. Stall=0 -> Out=400 on the next edge.
//   - Reset=1 together with Stall=1 and In=500 -> Out=RESET_VECTOR after one edge.
//   - In=32'hFFFF_FFFC -> OutPlus4=0.
//   - In=32'd202:
//     - Macro undefined -> Out=202, Misaligned=1.
//     - PC_ALIGN_FORCE_EN defined -> Out=200, Misaligned=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: PC width, boot vector and instruction size.
package mips_pkg;

  localparam int                   PC_WIDTH        = 32;
  localparam logic [PC_WIDTH-1:0]  PC_RESET_VECTOR = 32'h0000_0000;
  localparam int                   INSTR_BYTES     = 4;

  // A PC is misaligned when it does not point at a word boundary.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/pc_register_dff_en_rst.sv
// Generic register with synchronous active-high reset and load enable.
module dff_en_rst #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Reset wins over the enable, so a reset during a hold still takes effect.
  always_ff @(posedge clk) begin
    if (srst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pc_register.sv
// IF-stage program counter with stall hold, boot-vector reset and PC+4 output.
// Build option PC_ALIGN_FORCE_EN: force loaded PCs to word alignment.
module pc_register
  import mips_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] OutPlus4,
  output logic             Misaligned
);

  localparam logic RESET_MIS = (RESET_VECTOR[1:0] != 2'b00);

  logic [WIDTH-1:0] load_pc;
  logic             load_mis;
  logic [WIDTH:0]   state_d;
  logic [WIDTH:0]   state_q;

  always_comb begin
    load_mis = is_misaligned(In[1:0]);
`ifdef PC_ALIGN_FORCE_EN
    // The flag keeps reporting the raw request even though the PC is aligned.
    load_pc      = In;
    load_pc[1:0] = 2'b00;
`else
    load_pc = In;
`endif
    state_d = {load_mis, load_pc};
  end

  // The flag rides in the same register as the PC so both move together.
  dff_en_rst #(
    .WIDTH   (WIDTH + 1),
    .RST_VAL ({RESET_MIS, RESET_VECTOR})
  ) u_pc_q (
    .clk  (Clk),
    .srst (Reset),
    .en   (~Stall),
    .d    (state_d),
    .q    (state_q)
  );

  assign Out        = state_q[WIDTH-1:0];
  assign Misaligned = state_q[WIDTH];
  assign OutPlus4   = state_q[WIDTH-1:0] + WIDTH'(INSTR_BYTES);

endmodule

// File: tb/tb_pc_register.sv
// Scoreboard bench for pc_register: stimulus queues expectations, a monitor checks each edge.
module tb_pc_register;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        mis;
    logic [31:0] p4;
  } exp_t;

`ifdef PC_ALIGN_FORCE_EN
  localparam logic [31:0] EXP_202 = 32'd200;
  localparam logic [31:0] EXP_3   = 32'd0;
`else
  localparam logic [31:0] EXP_202 = 32'd202;
  localparam logic [31:0] EXP_3   = 32'd3;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic [31:0] In;
  logic [31:0] Out;
  logic [31:0] OutPlus4;
  logic        Misaligned;

  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;

  pc_register #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Stall      (Stall),
    .In         (In),
    .Out        (Out),
    .OutPlus4   (OutPlus4),
    .Misaligned (Misaligned)
  );

  task automatic drive(input string name, input logic r, input logic s, input logic [31:0] in_v,
                       input logic [31:0] e_out, input logic e_mis, input logic [31:0] e_p4);
    exp_t e;
    @(negedge Clk);
    Reset = r;
    Stall = s;
    In    = in_v;
    @(posedge Clk);
    e.name = name;
    e.out  = e_out;
    e.mis  = e_mis;
    e.p4   = e_p4;
    sb_q.push_back(e);
  endtask

  // Monitor: the registered outputs are valid just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        checks += 3;
        if (Out !== e.out) begin
          errors++;
          $display("FAIL %s out: got %h expected %h", e.name, Out, e.out);
        end
        if (Misaligned !== e.mis) begin
          errors++;
          $display("FAIL %s misaligned: got %b expected %b", e.name, Misaligned, e.mis);
        end
        if (OutPlus4 !== e.p4) begin
          errors++;
          $display("FAIL %s plus4: got %h expected %h", e.name, OutPlus4, e.p4);
        end
        $display("txn %0d %s: Out=%h Misaligned=%b OutPlus4=%h", txn, e.name, Out, Misaligned, OutPlus4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    Stall = 1'b0;
    In    = 32'd0;
    //    name            R     S     In             Out            Mis   Plus4
    drive("reset_0",      1'b1, 1'b0, 32'd0,         32'd0,         1'b0, 32'd4);
    drive("reset_1",      1'b1, 1'b0, 32'd0,         32'd0,         1'b0, 32'd4);
    drive("load_0",       1'b0, 1'b0, 32'd0,         32'd0,         1'b0, 32'd4);
    drive("load_200",     1'b0, 1'b0, 32'd200,       32'd200,       1'b0, 32'd204);
    drive("keep_200",     1'b0, 1'b0, 32'd200,       32'd200,       1'b0, 32'd204);
    drive("load_300",     1'b0, 1'b0, 32'd300,       32'd300,       1'b0, 32'd304);
    drive("stall_1",      1'b0, 1'b1, 32'd400,       32'd300,       1'b0, 32'd304);
    drive("stall_2",      1'b0, 1'b1, 32'd400,       32'd300,       1'b0, 32'd304);
    drive("stall_3",      1'b0, 1'b1, 32'd400,       32'd300,       1'b0, 32'd304);
    drive("unstall_400",  1'b0, 1'b0, 32'd400,       32'd400,       1'b0, 32'd404);
    drive("rst_in_stall", 1'b1, 1'b1, 32'd500,       32'd0,         1'b0, 32'd4);
    drive("hold_vector",  1'b0, 1'b1, 32'd500,       32'd0,         1'b0, 32'd4);
    drive("load_500",     1'b0, 1'b0, 32'd500,       32'd500,       1'b0, 32'd504);
    drive("wrap_plus4",   1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'd0);
    drive("misalign_202", 1'b0, 1'b0, 32'd202,       EXP_202,       1'b1, EXP_202 + 32'd4);
    drive("stall_mis",    1'b0, 1'b1, 32'd8,         EXP_202,       1'b1, EXP_202 + 32'd4);
    drive("load_8",       1'b0, 1'b0, 32'd8,         32'd8,         1'b0, 32'd12);
    drive("misalign_3",   1'b0, 1'b0, 32'd3,         EXP_3,         1'b1, EXP_3 + 32'd4);
    drive("reset_final",  1'b1, 1'b0, 32'd7,         32'd0,         1'b0, 32'd4);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
